// File: rtl/control_sequencer.sv
// Microcoded control sequencer: six-stage fetch/execute FSM producing a 15-bit
// control word from stage, decoded opcode and ALU flags, with optional single-step.
module control_sequencer #(
  parameter int OPW     = 4,
  parameter int STEP_EN = 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  input  logic           step_mode,
  input  logic           step,
  output logic [14:0]    ctrl,
  output logic [2:0]     stage,
  output logic           halted,
  output logic           instr_done
);

  // state   | meaning
  // S_T0    | fetch: PC onto bus, load MAR
  // S_T1    | fetch: increment PC
  // S_T2    | fetch: RAM into IR (last stage of NOP)
  // S_T3    | execute 1 (last of HLT/OUT/JMP/JC/JZ)
  // S_T4    | execute 2 (last of LDA)
  // S_T5    | execute 3 (last of ADD/SUB/STA)
  // S_RST   | post-reset, idle word, next is T0
  // S_HALT  | terminal after HLT, left only by reset
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_RST  = 3'd6,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_HLT = 4'd0, OP_NOP = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_LDA = 4'd4,
    OP_OUT = 4'd5, OP_STA = 4'd6, OP_JMP = 4'd7, OP_JC  = 4'd8, OP_JZ  = 4'd9
  } op_t;

  localparam logic [14:0] W_IDLE    = 15'h0FE3;
  localparam logic [14:0] W_T0      = 15'h27E3;
  localparam logic [14:0] W_T1      = 15'h4FE3;
  localparam logic [14:0] W_T2      = 15'h0D63;
  localparam logic [14:0] W_IR_MAR  = 15'h07A3;
  localparam logic [14:0] W_OUT     = 15'h0FF2;
  localparam logic [14:0] W_JMP     = 15'h1FA3;
  localparam logic [14:0] W_RAM_B   = 15'h0DE1;
  localparam logic [14:0] W_RAM_A   = 15'h0DC3;
  localparam logic [14:0] W_A_MEM   = 15'h0BF3;
  localparam logic [14:0] W_ADD     = 15'h0FC7;
  localparam logic [14:0] W_SUB     = 15'h0FCF;
  localparam logic [14:0] W_RAM_WR  = 15'h0EE3;

  state_t state, state_next, last_stage;
  op_t    op;
  logic   advance;

  // Anything outside 0..9 (including upper codes when OPW>4) decodes as NOP.
  always_comb begin
    op = OP_NOP;
    if (opcode < OPW'(10))
      op = op_t'(opcode[3:0]);
  end

  always_comb begin
    last_stage = S_T3;
    case (op)
      OP_NOP:                 last_stage = S_T2;
      OP_LDA:                 last_stage = S_T4;
      OP_ADD, OP_SUB, OP_STA: last_stage = S_T5;
      default:                last_stage = S_T3;
    endcase
  end

  assign advance = !((STEP_EN != 0) && step_mode) || step;

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= S_RST;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:   if (advance) state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: begin
        if (advance) begin
          if (state == last_stage)
            state_next = (op == OP_HLT) ? S_HALT : S_T0;
          else
            state_next = state_t'(state + 3'd1);
        end
      end
    endcase
  end

  always_comb begin
    ctrl = W_IDLE;
    case (state)
      S_T0: ctrl = W_T0;
      S_T1: ctrl = W_T1;
      S_T2: ctrl = W_T2;
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_LDA, OP_STA: ctrl = W_IR_MAR;
          OP_OUT:  ctrl = W_OUT;
          OP_JMP:  ctrl = W_JMP;
          OP_JC:   ctrl = flag_c ? W_JMP : W_IDLE;
          OP_JZ:   ctrl = flag_z ? W_JMP : W_IDLE;
          default: ctrl = W_IDLE;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB: ctrl = W_RAM_B;
          OP_LDA:  ctrl = W_RAM_A;
          OP_STA:  ctrl = W_A_MEM;
          default: ctrl = W_IDLE;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD:  ctrl = W_ADD;
          OP_SUB:  ctrl = W_SUB;
          OP_STA:  ctrl = W_RAM_WR;
          default: ctrl = W_IDLE;
        endcase
      end
      default: ctrl = W_IDLE;
    endcase
  end

  assign stage  = state;
  assign halted = (state == S_HALT);
  // A pending reset means the stage will not advance, so no completion is flagged.
  assign instr_done = resetn && advance && (state != S_RST) && (state != S_HALT)
                      && (state == last_stage);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected stage/ctrl/done/halted
// tuples are queued per cycle and compared mid-cycle against the DUT.
module tb_control_sequencer;
  localparam int OPW = 6;

  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, RST = 3'd6, HALT = 3'd7;

  logic           clk = 1'b0;
  logic           resetn;
  logic [OPW-1:0] opcode;
  logic           flag_c, flag_z, step_mode, step;
  logic [14:0]    ctrl;
  logic [2:0]     stage;
  logic           halted, instr_done;

  typedef struct packed {
    logic [2:0]  stage;
    logic [14:0] ctrl;
    logic        done;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  control_sequencer #(.OPW(OPW), .STEP_EN(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .step_mode  (step_mode),
    .step       (step),
    .ctrl       (ctrl),
    .stage      (stage),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared at the
  // following falling edge, so instr_done reflects the inputs for the next edge.
  task automatic expect_cyc(input logic [2:0] s, input logic [14:0] c,
                            input logic d, input logic h);
    exp_t e;
    e = '{stage: s, ctrl: c, done: d, halted: h};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("stage",      32'(stage),      32'(e.stage));
    check("ctrl",       32'(ctrl),       32'(e.ctrl));
    check("instr_done", 32'(instr_done), 32'(e.done));
    check("halted",     32'(halted),     32'(e.halted));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic done_t2);
    expect_cyc(T0, 15'h27E3, 1'b0, 1'b0);
    expect_cyc(T1, 15'h4FE3, 1'b0, 1'b0);
    expect_cyc(T2, 15'h0D63, done_t2, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; opcode = OPW'(1); flag_c = 1'b0; flag_z = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    @(posedge clk); #1;
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);

    // NOP after reset release
    resetn = 1'b1;
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);
    fetch(1'b1);

    // SUB twice back to back
    opcode = OPW'(3);
    for (int i = 0; i < 2; i++) begin
      fetch(1'b0);
      expect_cyc(T3, 15'h07A3, 1'b0, 1'b0);
      expect_cyc(T4, 15'h0DE1, 1'b0, 1'b0);
      expect_cyc(T5, 15'h0FCF, 1'b1, 1'b0);
    end

    opcode = OPW'(2);
    fetch(1'b0);
    expect_cyc(T3, 15'h07A3, 1'b0, 1'b0);
    expect_cyc(T4, 15'h0DE1, 1'b0, 1'b0);
    expect_cyc(T5, 15'h0FC7, 1'b1, 1'b0);

    opcode = OPW'(4);
    fetch(1'b0);
    expect_cyc(T3, 15'h07A3, 1'b0, 1'b0);
    expect_cyc(T4, 15'h0DC3, 1'b1, 1'b0);

    opcode = OPW'(6);
    fetch(1'b0);
    expect_cyc(T3, 15'h07A3, 1'b0, 1'b0);
    expect_cyc(T4, 15'h0BF3, 1'b0, 1'b0);
    expect_cyc(T5, 15'h0EE3, 1'b1, 1'b0);

    opcode = OPW'(5);
    fetch(1'b0);
    expect_cyc(T3, 15'h0FF2, 1'b1, 1'b0);

    opcode = OPW'(7);
    fetch(1'b0);
    expect_cyc(T3, 15'h1FA3, 1'b1, 1'b0);

    // Conditional jumps; the opposite flag is set to catch a swapped flag
    opcode = OPW'(8); flag_c = 1'b1; flag_z = 1'b0;
    fetch(1'b0);
    expect_cyc(T3, 15'h1FA3, 1'b1, 1'b0);
    flag_c = 1'b0; flag_z = 1'b1;
    fetch(1'b0);
    expect_cyc(T3, 15'h0FE3, 1'b1, 1'b0);
    opcode = OPW'(9); flag_c = 1'b0; flag_z = 1'b1;
    fetch(1'b0);
    expect_cyc(T3, 15'h1FA3, 1'b1, 1'b0);
    flag_c = 1'b1; flag_z = 1'b0;
    fetch(1'b0);
    expect_cyc(T3, 15'h0FE3, 1'b1, 1'b0);
    flag_c = 1'b0;

    // Undefined opcodes behave as NOP
    opcode = OPW'(8'h2A);
    fetch(1'b1);
    opcode = OPW'(10);
    fetch(1'b1);

    // Single-step with OUT
    opcode = OPW'(5); step_mode = 1'b1; step = 1'b1;
    fetch(1'b0);
    step = 1'b0;
    for (int i = 0; i < 5; i++) expect_cyc(T3, 15'h0FF2, 1'b0, 1'b0);
    step = 1'b1;
    expect_cyc(T3, 15'h0FF2, 1'b1, 1'b0);
    step = 1'b0;
    expect_cyc(T0, 15'h27E3, 1'b0, 1'b0);
    expect_cyc(T0, 15'h27E3, 1'b0, 1'b0);
    step = 1'b1;
    expect_cyc(T0, 15'h27E3, 1'b0, 1'b0);
    step = 1'b0;
    expect_cyc(T1, 15'h4FE3, 1'b0, 1'b0);
    step_mode = 1'b0;
    expect_cyc(T1, 15'h4FE3, 1'b0, 1'b0);
    expect_cyc(T2, 15'h0D63, 1'b0, 1'b0);
    expect_cyc(T3, 15'h0FF2, 1'b1, 1'b0);

    // HLT, then step activity must not leave HALT
    opcode = OPW'(0);
    fetch(1'b0);
    expect_cyc(T3, 15'h0FE3, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step      = 1'($urandom_range(0, 1));
      step_mode = 1'(i % 2);
      expect_cyc(HALT, 15'h0FE3, 1'b0, 1'b1);
    end
    step_mode = 1'b0; step = 1'b0;
    resetn = 1'b0;
    expect_cyc(HALT, 15'h0FE3, 1'b0, 1'b1);
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);

    // Reset during LDA T4 abandons the instruction
    resetn = 1'b1; opcode = OPW'(4);
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);
    fetch(1'b0);
    expect_cyc(T3, 15'h07A3, 1'b0, 1'b0);
    resetn = 1'b0;
    expect_cyc(T4, 15'h0DC3, 1'b0, 1'b0);
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);
    resetn = 1'b1;
    expect_cyc(RST, 15'h0FE3, 1'b0, 1'b0);
    expect_cyc(T0, 15'h27E3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
